// File: rtl/pc_pkg.sv
// Shared definitions for the fetch program-counter logic: FSM states,
// next-PC select codes and the default vector/increment constants.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } pc_state_e;

    // Which source feeds the next fetch PC, in priority order.
    typedef enum logic [2:0] {
        SEL_HOLD  = 3'd0,
        SEL_TRAP  = 3'd1,
        SEL_REDIR = 3'd2,
        SEL_LATCH = 3'd3,
        SEL_PEND  = 3'd4,
        SEL_INC   = 3'd5
    } pc_sel_e;

    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0004;
    localparam int          DEF_INC       = 4;

endpackage

// File: rtl/pc_gen_next_mux.sv
// Combinational next-PC priority select: trap > redirect > pending > advance > hold.
// Also produces the INC-aligned redirect target and its misalignment flag.
module pc_next_mux
    import pc_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] TRAP_VEC = DEF_TRAP_VEC[XLEN-1:0],
    parameter int              INC      = DEF_INC
) (
    input  pc_state_e       i_state,
    input  logic            i_pc_write,
    input  logic            i_fetch_ready,
    input  logic            i_redirect_valid,
    input  logic [XLEN-1:0] i_redirect_pc,
    input  logic            i_trap,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_pend_pc,
    output pc_sel_e         o_sel,
    output logic [XLEN-1:0] o_next_pc,
    output logic [XLEN-1:0] o_aligned_pc,
    output logic            o_misalign,
    output logic            o_advance
);

    localparam logic [XLEN-1:0] INC_MASK = XLEN'(INC - 1);

    logic w_valid;

    assign w_valid      = (i_state != BOOT);
    assign o_advance    = w_valid & i_pc_write & i_fetch_ready;
    assign o_aligned_pc = i_redirect_pc & ~INC_MASK;
    assign o_misalign   = |(i_redirect_pc & INC_MASK);

    // A redirect seen in BOOT is always parked, even with pc_write_i high.
    always_comb begin
        o_sel = SEL_HOLD;
        if (i_trap) begin
            o_sel = SEL_TRAP;
        end else if (i_redirect_valid && i_pc_write && w_valid) begin
            o_sel = SEL_REDIR;
        end else if (i_redirect_valid) begin
            o_sel = SEL_LATCH;
        end else if (i_state == PEND && i_pc_write) begin
            o_sel = SEL_PEND;
        end else if (o_advance) begin
            o_sel = SEL_INC;
        end
    end

    always_comb begin
        o_next_pc = i_pc;
        case (o_sel)
            SEL_TRAP:  o_next_pc = TRAP_VEC;
            SEL_REDIR: o_next_pc = o_aligned_pc;
            SEL_PEND:  o_next_pc = i_pend_pc;
            SEL_INC:   o_next_pc = i_pc + XLEN'(INC);
            default:   o_next_pc = i_pc;
        endcase
    end

endmodule

// File: rtl/pc_gen.sv
// IF-stage program-counter generator: holds the fetch PC, advances it on
// accepted fetches, and applies traps/redirects, parking redirects during stalls.
module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = DEF_RESET_VEC[XLEN-1:0],
    parameter logic [XLEN-1:0] TRAP_VEC  = DEF_TRAP_VEC[XLEN-1:0],
    parameter int              INC       = DEF_INC
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            pc_write_i,
    input  logic            fetch_ready_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            trap_i,
    output logic [XLEN-1:0] pc_o,
    output logic            pc_valid_o,
    output logic [XLEN-1:0] pc_prev_o,
    output logic            misalign_o,
    output logic            pending_o
);

    // Fetch handshake: pc_o is offered while pc_valid_o=1 and accepted on a cycle
    // where pc_write_i & fetch_ready_i are also 1; until then the request is
    // held stable, unless a trap or redirect replaces it.

    pc_state_e       r_state;
    pc_state_e       w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_pc_prev;
    logic [XLEN-1:0] r_pend_pc;
    logic            r_misalign;

    pc_sel_e         w_sel;
    logic [XLEN-1:0] w_next_pc;
    logic [XLEN-1:0] w_aligned_pc;
    logic            w_misalign;
    logic            w_advance;

    pc_next_mux #(
        .XLEN     (XLEN),
        .TRAP_VEC (TRAP_VEC),
        .INC      (INC)
    ) u_next_mux (
        .i_state          (r_state),
        .i_pc_write       (pc_write_i),
        .i_fetch_ready    (fetch_ready_i),
        .i_redirect_valid (redirect_valid_i),
        .i_redirect_pc    (redirect_pc_i),
        .i_trap           (trap_i),
        .i_pc             (r_pc),
        .i_pend_pc        (r_pend_pc),
        .o_sel            (w_sel),
        .o_next_pc        (w_next_pc),
        .o_aligned_pc     (w_aligned_pc),
        .o_misalign       (w_misalign),
        .o_advance        (w_advance)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            BOOT: w_state_nxt = (w_sel == SEL_LATCH) ? PEND : RUN;
            RUN, PEND: begin
                case (w_sel)
                    SEL_TRAP, SEL_REDIR, SEL_PEND: w_state_nxt = RUN;
                    SEL_LATCH:                     w_state_nxt = PEND;
                    default:                       w_state_nxt = r_state;
                endcase
            end
            default: w_state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= BOOT;
            r_pc       <= RESET_VEC;
            r_pc_prev  <= RESET_VEC;
            r_pend_pc  <= '0;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_next_pc;
            r_misalign <= (w_sel == SEL_REDIR || w_sel == SEL_LATCH) && w_misalign;
            if (w_advance) begin
                r_pc_prev <= r_pc;
            end
            // Newest stalled redirect wins; a taken trap/redirect discards it.
            if (w_sel == SEL_LATCH) begin
                r_pend_pc <= w_aligned_pc;
            end else if (w_sel == SEL_TRAP || w_sel == SEL_REDIR) begin
                r_pend_pc <= '0;
            end
        end
    end

    assign pc_o       = r_pc;
    assign pc_valid_o = (r_state != BOOT);
    assign pc_prev_o  = r_pc_prev;
    assign misalign_o = r_misalign;
    assign pending_o  = (r_state == PEND);

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the pipelined RISC-V core's IF stage. It holds the fetch PC and advances it sequentially when the pipeline allows. It applies branch/jump redirects and trap vectors by fixed priority. Redirects that arrive while the PC is stalled are held in a pending register and are never lost.

## Interface
- XLEN, 32, PC width in bits
- RESET_VEC, 32'h0000_0000, PC value loaded during reset
- TRAP_VEC, 32'h0000_0004, PC loaded on trap
- INC, 4, sequential increment; power of two, ≥ 2
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-low; clock clk_i
- pc_write_i  in  1  1 = PC may advance this cycle (0 = hazard stall)
- fetch_ready_i  in  1  instruction memory accepts pc_o this cycle
- redirect_valid_i  in  1  one-cycle pulse: branch/jump taken
- redirect_pc_i  in  XLEN  redirect target
- trap_i  in  1  one-cycle pulse: take trap
- pc_o  out  XLEN  current fetch PC
- pc_valid_o  out  1  pc_o is a valid fetch request
- pc_prev_o  out  XLEN  PC of the last accepted fetch
- misalign_o  out  1  one-cycle pulse: redirect target not INC-aligned
- pending_o  out  1  a held redirect is waiting

## Operation
- FSM states: BOOT, RUN, PEND.
- Reset (rst_i=0): state BOOT; pc_o=RESET_VEC; pc_prev_o=RESET_VEC; pc_valid_o=0; misalign_o=0; pending_o=0; pending target register=0.
- BOOT: pc_valid_o=0. Moves to RUN on the first clock edge after reset release. pc_o is unchanged.
- advance = pc_valid_o & pc_write_i & fetch_ready_i. On advance, pc_prev_o <= pc_o.
- Next-PC priority at each edge in RUN/PEND:
  - trap_i: pc_o <= TRAP_VEC. Applied regardless of pc_write_i or fetch_ready_i. Pending is cleared and state goes to RUN.
  - redirect_valid_i with pc_write_i=1: pc_o <= redirect_pc_i with low log2(INC) bits forced to 0. Pending is cleared and state goes to RUN. fetch_ready_i does not gate this; a redirect kills the current request.
  - redirect_valid_i with pc_write_i=0: target is latched into the pending register and state goes to PEND. pc_o is unchanged.
  - PEND with pc_write_i=1 and no new redirect or trap: pc_o <= pending target; state goes to RUN.
  - PEND with a new redirect while pc_write_i=0: the pending target is overwritten (newest wins).
  - Otherwise, on advance: pc_o <= pc_o + INC, modulo 2^XLEN (wraps, no flag).
  - Otherwise: hold.
- A redirect arriving in BOOT is latched as pending (state goes to PEND); a trap in BOOT loads TRAP_VEC and goes to RUN. In both cases pc_valid_o rises on the next cycle as usual.
- misalign_o is asserted the cycle after any accepted or latched redirect whose redirect_pc_i[log2(INC)-1:0] ≠ 0. The aligned value is still used.
- pending_o = (state == PEND).

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- Redirect or trap to new pc_o: 1 cycle.
- Pending redirect to pc_o: 1 cycle after the first cycle with pc_write_i=1.
- Sequential advance: 1 cycle per accepted fetch. Throughput is 1 PC per cycle while advance=1.
- pc_valid_o=1 continuously in RUN/PEND. A request is held stable until accepted, unless a trap or redirect replaces it.
- Simultaneous trap_i and redirect_valid_i: trap wins and the redirect is dropped.
- Async reset mid-operation: all state returns to reset values immediately; any pending redirect is discarded.

## Structure
- Shared package pc_pkg: state enum (BOOT, RUN, PEND); default RESET_VEC, TRAP_VEC and INC constants reused by the decode and exception blocks.
- One natural sub-module: pc_next_mux (combinational priority select and alignment). The FSM, pc_o, pc_prev_o and the pending register stay in pc_gen.

## Test plan
- Reset then release with pc_write_i=1, fetch_ready_i=1: pc_valid_o=0 for 1 cycle, then pc_o = 0, 4, 8, 12; pc_prev_o lags by one accepted fetch.
- fetch_ready_i=0 for 3 cycles at pc_o=0x10: pc_o holds 0x10 and pc_valid_o stays 1; resumes to 0x14 after ready.
- Redirect to 0x200 while pc_write_i=0: pending_o=1 and pc_o holds; a second redirect to 0x300 is still stalled; release the stall and pc_o=0x300 next cycle with pending_o=0.
- trap_i and redirect to 0x400 in the same cycle, with pc_write_i=0: pc_o=TRAP_VEC (0x4) next cycle and pending_o=0.
- Redirect to 0x203 with INC=4: pc_o=0x200 and misalign_o pulses for 1 cycle.
- pc_o=0xFFFF_FFFC and advance: pc_o=0x0000_0000. Then assert rst_i=0 while in PEND: immediately pc_o=RESET_VEC, pending_o=0, pc_valid_o=0.
